// File: rtl/soc_fifo_access_ctrl.sv
// soc_fifo_access_ctrl
// Front-end sequencer for the SoC FIFO memory sub-block. It programs the FIFO CSR bank
// after reset, then polls fill level and services interrupts. Alongside that it arbitrates
// two producers onto the FIFO write slave and serves one consumer from the read slave.
//
// Handshake semantics:
//   Producers hold pN_valid and pN_data stable until pN_ack. pN_ack is a one-cycle pulse
//   meaning the word has been captured, so the producer may present its next word.
//   The consumer pulses c_pop from idle. c_valid is a one-cycle pulse, and c_data holds
//   the popped word until the next pop completes.
//   On the Avalon-MM side, fifo_wr_write and fifo_rd_read stay asserted with stable
//   payload until a clock edge on which the matching waitrequest is low.
//   csr_read and csr_write are single-cycle strobes. csr_readdata is valid one cycle
//   after csr_read.
module soc_fifo_access_ctrl #(
    parameter int          DATA_W       = 32,
    parameter int          ALMOST_FULL  = 12,
    parameter int          ALMOST_EMPTY = 4,
    parameter logic [5:0]  IRQ_EN       = 6'h3C,
    parameter int          POLL_PERIOD  = 64
) (
    input  logic              wrclock,
    input  logic              reset,
    input  logic              p0_valid,
    input  logic [DATA_W-1:0] p0_data,
    output logic              p0_ack,
    input  logic              p1_valid,
    input  logic [DATA_W-1:0] p1_data,
    output logic              p1_ack,
    input  logic              c_pop,
    output logic              c_valid,
    output logic [DATA_W-1:0] c_data,
    output logic              c_busy,
    output logic              fifo_wr_write,
    output logic [DATA_W-1:0] fifo_wr_writedata,
    input  logic              fifo_wr_waitrequest,
    output logic              fifo_rd_read,
    input  logic [DATA_W-1:0] fifo_rd_readdata,
    input  logic              fifo_rd_waitrequest,
    output logic [2:0]        csr_address,
    output logic              csr_read,
    output logic              csr_write,
    output logic [31:0]       csr_writedata,
    input  logic [31:0]       csr_readdata,
    input  logic              csr_irq,
    output logic              cfg_done,
    output logic [31:0]       fill_level,
    output logic [5:0]        evt_flags
);

    localparam int CNT_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_PERIOD - 1);

    // ------------------------------------------------------------------
    // CSR sequencer
    // ------------------------------------------------------------------
    typedef enum logic [3:0] {
        CSR_CFG_AF    = 4'd0,
        CSR_CFG_AE    = 4'd1,
        CSR_CFG_IE    = 4'd2,
        CSR_IDLE      = 4'd3,
        CSR_POLL_RD   = 4'd4,
        CSR_POLL_WAIT = 4'd5,
        CSR_EVT_RD    = 4'd6,
        CSR_EVT_WAIT  = 4'd7,
        CSR_EVT_CLR   = 4'd8
    } csr_state_t;

    csr_state_t       csr_state;
    csr_state_t       csr_next;
    logic [CNT_W-1:0] poll_cnt;

    // CSR state register; reset restarts the programming sequence
    always_ff @(posedge wrclock) begin
        if (reset) csr_state <= CSR_CFG_AF;
        else       csr_state <= csr_next;
    end

    // CSR next state: interrupt service wins over a due poll
    always_comb begin
        csr_next = csr_state;
        case (csr_state)
            CSR_CFG_AF:    csr_next = CSR_CFG_AE;
            CSR_CFG_AE:    csr_next = CSR_CFG_IE;
            CSR_CFG_IE:    csr_next = CSR_IDLE;
            CSR_IDLE: begin
                if (csr_irq)                    csr_next = CSR_EVT_RD;
                else if (poll_cnt == POLL_LAST) csr_next = CSR_POLL_RD;
            end
            CSR_POLL_RD:   csr_next = CSR_POLL_WAIT;
            CSR_POLL_WAIT: csr_next = CSR_IDLE;
            CSR_EVT_RD:    csr_next = CSR_EVT_WAIT;
            CSR_EVT_WAIT:  csr_next = CSR_EVT_CLR;
            CSR_EVT_CLR:   csr_next = CSR_IDLE;
            default:       csr_next = CSR_CFG_AF;
        endcase
    end

    // CSR bus strobes; held quiet while reset is asserted
    always_comb begin
        csr_read      = 1'b0;
        csr_write     = 1'b0;
        csr_address   = 3'd0;
        csr_writedata = 32'd0;
        case (csr_state)
            CSR_CFG_AF: begin
                csr_write     = 1'b1;
                csr_address   = 3'd4;
                csr_writedata = 32'(ALMOST_FULL);
            end
            CSR_CFG_AE: begin
                csr_write     = 1'b1;
                csr_address   = 3'd5;
                csr_writedata = 32'(ALMOST_EMPTY);
            end
            CSR_CFG_IE: begin
                csr_write     = 1'b1;
                csr_address   = 3'd3;
                csr_writedata = {26'd0, IRQ_EN};
            end
            CSR_POLL_RD: begin
                csr_read    = 1'b1;
                csr_address = 3'd0;
            end
            CSR_EVT_RD: begin
                csr_read    = 1'b1;
                csr_address = 3'd2;
            end
            CSR_EVT_CLR: begin
                // event register is write-1-to-clear: write back exactly what was seen
                csr_write     = 1'b1;
                csr_address   = 3'd2;
                csr_writedata = {26'd0, evt_flags};
            end
            default: ;
        endcase
        if (reset) begin
            csr_read      = 1'b0;
            csr_write     = 1'b0;
            csr_address   = 3'd0;
            csr_writedata = 32'd0;
        end
    end

    // CSR datapath: config-done flag, poll counter, captured read values
    always_ff @(posedge wrclock) begin
        if (reset) begin
            cfg_done   <= 1'b0;
            poll_cnt   <= '0;
            fill_level <= 32'd0;
            evt_flags  <= 6'd0;
        end else begin
            if (csr_state == CSR_CFG_IE) cfg_done <= 1'b1;
            // counter saturates so a poll that came due during irq service is not lost
            if (csr_state == CSR_IDLE && poll_cnt != POLL_LAST) poll_cnt <= poll_cnt + 1'b1;
            if (csr_state == CSR_POLL_WAIT) begin
                fill_level <= csr_readdata;
                poll_cnt   <= '0;
            end
            if (csr_state == CSR_EVT_WAIT) evt_flags <= csr_readdata[5:0];
        end
    end

    // ------------------------------------------------------------------
    // Write path: round-robin between two producers
    // ------------------------------------------------------------------
    typedef enum logic {
        W_IDLE = 1'b0,
        W_BUSY = 1'b1
    } w_state_t;

    w_state_t          w_state;
    w_state_t          w_next;
    logic              last_p1;
    logic              grant_p1;
    logic              w_start;
    logic [DATA_W-1:0] wr_data;

    // with both requesting, the producer not granted last time wins
    assign grant_p1 = p1_valid && (!p0_valid || !last_p1);
    assign w_start  = (w_state == W_IDLE) && cfg_done && (p0_valid || p1_valid);

    // write state register
    always_ff @(posedge wrclock) begin
        if (reset) w_state <= W_IDLE;
        else       w_state <= w_next;
    end

    // write next state: one grant per transfer, held until the slave accepts
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (w_start) w_next = W_BUSY;
            W_BUSY:  if (!fifo_wr_waitrequest) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // write outputs
    always_comb begin
        fifo_wr_write     = (w_state == W_BUSY);
        fifo_wr_writedata = wr_data;
    end

    // write datapath: latch granted word, pulse ack, move round-robin pointer
    always_ff @(posedge wrclock) begin
        if (reset) begin
            wr_data <= '0;
            last_p1 <= 1'b1;
            p0_ack  <= 1'b0;
            p1_ack  <= 1'b0;
        end else begin
            p0_ack <= w_start && !grant_p1;
            p1_ack <= w_start && grant_p1;
            if (w_start) begin
                wr_data <= grant_p1 ? p1_data : p0_data;
                last_p1 <= grant_p1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path: single consumer
    // ------------------------------------------------------------------
    typedef enum logic {
        R_IDLE = 1'b0,
        R_BUSY = 1'b1
    } r_state_t;

    r_state_t r_state;
    r_state_t r_next;

    // read state register
    always_ff @(posedge wrclock) begin
        if (reset) r_state <= R_IDLE;
        else       r_state <= r_next;
    end

    // read next state: an empty FIFO simply keeps us waiting
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (cfg_done && c_pop) r_next = R_BUSY;
            R_BUSY:  if (!fifo_rd_waitrequest) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // read outputs
    always_comb begin
        fifo_rd_read = (r_state == R_BUSY);
        c_busy       = (r_state == R_BUSY);
    end

    // read datapath: capture accepted word and flag it for one cycle
    always_ff @(posedge wrclock) begin
        if (reset) begin
            c_data  <= '0;
            c_valid <= 1'b0;
        end else begin
            c_valid <= (r_state == R_BUSY) && !fifo_rd_waitrequest;
            if (r_state == R_BUSY && !fifo_rd_waitrequest) c_data <= fifo_rd_readdata;
        end
    end

endmodule
